// File: rtl/canny_frame_controller.sv
// canny_frame_controller: streams one image frame out of memory into the pixel_loader chain
// and tracks the output-grid position of each gradient result until the frame completes.
module canny_frame_controller #(
  parameter int IMG_PIXELS    = 262144,
  parameter int ADDR_W        = 18,
  parameter int OUT_W         = 508,
  parameter int OUT_PIXELS    = 258064,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              start,
  input  logic              pause,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        pixel_out,
  output logic              pixel_out_valid,
  input  logic              res_valid,
  output logic [9:0]        res_col,
  output logic [9:0]        res_row,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);
  localparam int CNT_W = $clog2(OUT_PIXELS + 1);
  localparam int IDL_W = $clog2(DRAIN_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [IDL_W-1:0]  r_idle, w_idle_nxt;
  logic [9:0]        r_col, r_row;
  logic              r_pix_valid, r_timeout;
  logic              w_start, w_rd, w_last, w_acc, w_full, w_to;
  assign w_start    = r_state == IDLE && start;
  assign w_rd       = r_state == FEED && !pause;
  assign w_last     = w_rd && r_addr == ADDR_W'(IMG_PIXELS - 1);
  assign w_acc      = res_valid && (r_state == FEED || r_state == DRAIN) && r_cnt < CNT_W'(OUT_PIXELS);
  assign w_cnt_nxt  = r_cnt + CNT_W'(w_acc);
  assign w_full     = w_cnt_nxt == CNT_W'(OUT_PIXELS);
  assign w_idle_nxt = res_valid ? '0 : r_idle + IDL_W'(1);
  // the DONE cycle itself is the DRAIN_TIMEOUT-th silent cycle after the last result
  assign w_to       = r_state == DRAIN && !res_valid && w_idle_nxt >= IDL_W'(DRAIN_TIMEOUT - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? FEED : IDLE;
      FEED:    w_next = !w_last ? FEED : w_full ? DONE : DRAIN;
      DRAIN:   w_next = (w_full || w_to) ? DONE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstN) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    r_pix_valid <= rstN && w_rd;
    if (!rstN || w_start) begin
      r_addr    <= '0;
      r_cnt     <= '0;
      r_idle    <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_rd) r_addr <= r_addr + ADDR_W'(1);
      r_cnt <= w_cnt_nxt;
      if (r_state == DRAIN) r_idle <= w_idle_nxt;
      if (w_to) r_timeout <= 1'b1;
      if (w_acc) begin
        r_col <= r_col == 10'(OUT_W - 1) ? '0 : r_col + 10'd1;
        if (r_col == 10'(OUT_W - 1)) r_row <= r_row + 10'd1;
      end
    end
  end
  assign mem_rd_en       = w_rd;
  assign mem_addr        = r_addr;
  assign pixel_out_valid = r_pix_valid;
  assign pixel_out       = r_pix_valid ? mem_rd_data : '0;
  assign res_col         = r_col;
  assign res_row         = r_row;
  assign busy            = r_state != IDLE;
  assign done            = r_state == DONE;
  assign timeout_err     = r_timeout;
endmodule

// File: tb/tb_canny_frame_controller.sv
// tb_canny_frame_controller: scoreboard bench for canny_frame_controller on a 16-pixel frame
// with a 2-wide, 4-result output grid and an 8-cycle drain timeout.
module tb_canny_frame_controller;
  localparam int IMG = 16, AW = 4, OW = 2, OP = 4, DT = 8;
  logic clk = 0, rstN = 0, start = 0, pause = 0, res_valid = 0;
  logic mem_rd_en, pixel_out_valid, busy, done, timeout_err;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_rd_data = 0, pixel_out;
  logic [9:0] res_col, res_row;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int done_cyc = 0, last_pix_cyc = 0, last_res_cyc = 0, done_cnt = 0, m_cnt = 0;
  bit done_seen = 0, prev_done = 0, exp_to = 0;
  logic [9:0] m_col = 0, m_row = 0;
  logic [19:0] pos;
  logic [7:0] rdq[$], pixq[$];
  logic [19:0] posq[$];
  canny_frame_controller #(
    .IMG_PIXELS(IMG), .ADDR_W(AW), .OUT_W(OW), .OUT_PIXELS(OP), .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk(clk), .rstN(rstN), .start(start), .pause(pause),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .pixel_out(pixel_out), .pixel_out_valid(pixel_out_valid),
    .res_valid(res_valid), .res_col(res_col), .res_row(res_row),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  // memory whose contents equal the address, data one cycle after the strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rd_data <= mem_rd_en ? 8'(mem_addr) : 8'hA5;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (pause) check("rd_paused", mem_rd_en, 0);
    if (busy && !pause && rdq.size() > 0) check("rd_continuous", mem_rd_en, 1);
    if (mem_rd_en) begin
      if (rdq.size() == 0) check("rd_extra", 1, 0);
      else check("rd_addr", mem_addr, rdq.pop_front());
    end
    if (pixel_out_valid) begin
      last_pix_cyc = cyc;
      if (pixq.size() == 0) check("pix_extra", 1, 0);
      else check("pixel", pixel_out, pixq.pop_front());
    end
    if (res_valid) begin
      last_res_cyc = cyc;
      if (posq.size() == 0) check("res_extra", 1, 0);
      else begin
        pos = posq.pop_front();
        check("res_row", res_row, pos[19:10]);
        check("res_col", res_col, pos[9:0]);
      end
    end
    if (prev_done) begin
      check("done_1cyc", done, 0);
      check("busy_after_done", busy, 0);
    end
    if (done) begin
      done_cyc = cyc;
      done_seen = 1;
      done_cnt++;
      check("timeout_err", timeout_err, exp_to);
    end
    prev_done = done;
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic kick();
    start = 1;
    done_seen = 0;
    done_cnt = 0;
    m_cnt = 0;
    m_col = 0;
    m_row = 0;
    for (int i = 0; i < IMG; i++) begin
      rdq.push_back(8'(i));
      pixq.push_back(8'(i));
    end
    check("busy_at_start", busy, 0);
    tick();
    start = 0;
    check("busy_in_feed", busy, 1);
  endtask
  task automatic send_res(input int n);
    for (int i = 0; i < n; i++) begin
      res_valid = 1;
      posq.push_back({m_row, m_col});
      if (m_cnt < OP) begin
        m_cnt++;
        if (m_col == 10'(OW - 1)) begin
          m_col = 0;
          m_row++;
        end else m_col++;
      end
      tick();
    end
    res_valid = 0;
  endtask
  task automatic wait_pix();
    int k = 0;
    while (pixq.size() > 0 && k < 64) begin
      tick();
      k++;
    end
    check("pix_drained", pixq.size(), 0);
  endtask
  task automatic wait_done();
    int k = 0;
    while (!done_seen && k < 64) begin
      tick();
      k++;
    end
    check("done_seen", done_seen, 1);
    tick(2);
    check("done_once", done_cnt, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tick(2);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pix_valid", pixel_out_valid, 0);
    check("rst_timeout", timeout_err, 0);
    rstN = 1;
    tick(3);
    check("idle_no_rd", mem_rd_en, 0);
    kick();
    wait_pix();
    send_res(4);
    wait_done();
    check("drain_done_lat", done_cyc - last_res_cyc, 1);
    kick();
    tick(5);
    pause = 1;
    tick(3);
    pause = 0;
    wait_pix();
    send_res(4);
    wait_done();
    kick();
    send_res(6);
    tick();
    start = 1;
    tick();
    start = 0;
    wait_pix();
    wait_done();
    check("early_done_lat", done_cyc - last_pix_cyc, 0);
    check("res_all_seen", posq.size(), 0);
    exp_to = 1;
    kick();
    wait_pix();
    send_res(2);
    wait_done();
    check("timeout_lat", done_cyc - last_res_cyc, 8);
    tick(3);
    check("timeout_sticky", timeout_err, 1);
    exp_to = 0;
    kick();
    check("timeout_cleared", timeout_err, 0);
    send_res(3);
    tick(6);
    rstN = 0;
    tick();
    rstN = 1;
    rdq.delete();
    pixq.delete();
    posq.delete();
    check("mrst_rd_en", mem_rd_en, 0);
    check("mrst_addr", mem_addr, 0);
    check("mrst_pixel", pixel_out, 0);
    check("mrst_pix_valid", pixel_out_valid, 0);
    check("mrst_res_col", res_col, 0);
    check("mrst_res_row", res_row, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_timeout", timeout_err, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_no_rd", mem_rd_en, 0);
    end
    kick();
    check("restart_addr", mem_addr, 0);
    wait_pix();
    send_res(4);
    wait_done();
    check("rdq_empty", rdq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/canny_frame_controller.md
CANNY_FRAME_CONTROLLER -- requirements
Module: canny_frame_controller

Interface
REQ-001 Parameter IMG_PIXELS, default 262144; pixels per input frame (512x512).
REQ-002 Parameter ADDR_W, default 18; image memory address width, where 2^ADDR_W >= IMG_PIXELS.
REQ-003 Parameter OUT_W, default 508; result pixels per output row.
REQ-004 Parameter OUT_PIXELS, default 258064; number of result pixels expected per frame.
REQ-005 Parameter DRAIN_TIMEOUT, default 1024; maximum run of consecutive idle cycles in DRAIN before an error is declared.
REQ-006 Clocking and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-007 clk  in  1  clock; all logic is on the rising edge.
REQ-008 rstN  in  1  synchronous active-low reset.
REQ-009 start  in  1  one-cycle request to process one frame.
REQ-010 pause  in  1  host stall; while high, no new memory read is issued.
REQ-011 mem_rd_en  out  1  image memory read strobe.
REQ-012 mem_addr  out  ADDR_W  image memory read address.
REQ-013 mem_rd_data  in  8  memory read data, valid exactly 1 cycle after mem_rd_en.
REQ-014 pixel_out  out  8  pixel sent to the first pixel_loader stage.
REQ-015 pixel_out_valid  out  1  qualifies pixel_out.
REQ-016 res_valid  in  1  result strobe from gradient_calculation (gradient_out_valid).
REQ-017 res_col  out  10  output-grid column of the current res_valid.
REQ-018 res_row  out  10  output-grid row of the current res_valid.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 done  out  1  one-cycle end-of-frame pulse.
REQ-021 timeout_err  out  1  sticky drain-timeout flag.

Function
REQ-022 The FSM SHALL have four states: IDLE, FEED, DRAIN, DONE.
REQ-023 IDLE->FEED on start=1. Entering FEED clears the address counter, result counter, res_col, res_row and timeout_err.
REQ-024 start SHALL be ignored in every state other than IDLE.
REQ-025 In FEED with pause=0, mem_rd_en=1 and mem_addr=current address; the address then increments by 1.
REQ-026 In FEED with pause=1, mem_rd_en=0 and the address holds.
REQ-027 pixel_out_valid SHALL equal mem_rd_en delayed 1 cycle, and pixel_out SHALL equal mem_rd_data in that cycle. Total read-to-pixel latency is 1 cycle.
REQ-028 A read issued in the cycle pause rises SHALL still produce its pixel on the next cycle; a pause SHALL NOT drop an in-flight read.
REQ-029 FEED->DRAIN in the cycle after the read of address IMG_PIXELS-1 is issued. Exactly IMG_PIXELS reads are issued per frame.
REQ-030 In FEED and DRAIN, each res_valid=1 cycle increments the result counter.
REQ-031 In the same cycle as each res_valid, res_col/res_row present the position of that result.
REQ-032 res_col advances by 1 per result and wraps from OUT_W-1 to 0; on that wrap res_row increments by 1.
REQ-033 res_valid SHALL be ignored in IDLE and DONE.
REQ-034 DRAIN->DONE when the result counter reaches OUT_PIXELS. Results that reach OUT_PIXELS during FEED SHALL cause FEED->DONE only after the last read is issued.
REQ-035 In DRAIN, an idle counter increments on every cycle with res_valid=0 and clears on res_valid=1.
REQ-036 When the idle counter reaches DRAIN_TIMEOUT, timeout_err SHALL be set and the FSM SHALL go to DONE.
REQ-037 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-038 timeout_err SHALL hold until the next IDLE->FEED transition.
REQ-039 Any res_valid beyond OUT_PIXELS SHALL NOT be counted.
REQ-040 pause has no effect outside FEED.

Reset
REQ-041 While rstN=0 at a rising edge, the FSM SHALL go to IDLE, including mid-frame.
REQ-042 That reset SHALL clear mem_rd_en, mem_addr, pixel_out, pixel_out_valid, res_col, res_row, busy, done, timeout_err and all internal counters to 0.
REQ-043 After rstN returns to 1, no read SHALL be issued until a new start.

Verification (IMG_PIXELS=16, OUT_W=2, OUT_PIXELS=4, DRAIN_TIMEOUT=8)
REQ-044 start, pause=0, memory data=address -> mem_rd_en high for 16 consecutive cycles at addr 0..15; pixel_out=0..15 one cycle later; busy=1 from the cycle after start.
REQ-045 4 res_valid pulses in DRAIN -> (res_row,res_col)=(0,0),(0,1),(1,0),(1,1); done pulses once; busy=0 the following cycle; timeout_err=0.
REQ-046 pause high for 3 cycles at addr 5 -> no reads issued for those 3 cycles; addr 5 is re-issued after release; pixel stream contains 0..15 with no gaps lost or duplicated.
REQ-047 Only 2 res_valid pulses, then silence -> timeout_err=1 and done pulse 8 cycles after the last res_valid; timeout_err stays 1 until the next start.
REQ-048 start pulsed during FEED at addr 7 -> ignored, addresses continue 8..15.
REQ-049 rstN=0 during FEED at addr 9 -> all outputs 0 on the next edge and FSM in IDLE; a fresh start restarts at addr 0.
